// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, grant encoding and request bundle
// for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_A    = 2'b01,
    GRANT_B    = 2'b10
  } grant_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Two-way round-robin arbiter; last_grant moves
// only when the granted write is accepted.
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // 1 = B granted most recently
  logic last_b_q;
  logic last_b_d;

  always_comb begin
    grant = GRANT_NONE;
    unique case (1'b1)
      req == 2'b11:
        grant = last_b_q ? GRANT_A : GRANT_B;
      req == 2'b01: grant = GRANT_A;
      req == 2'b10: grant = GRANT_B;
      default:      grant = GRANT_NONE;
    endcase
  end

  always_comb begin
    last_b_d = last_b_q;
    if (accept) last_b_d = grant[1];
  end

  always_ff @(posedge clk) begin
    if (rst) last_b_q <= 1'b1;
    else     last_b_q <= last_b_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges two writers onto one
// register-file port and tracks pending destinations.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]       a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0]       b_data,
  output logic                  b_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] chk_rs1,
  input  logic [REG_ADDR_W-1:0] chk_rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [XLEN-1:0]       write_data
);

  logic [1:0] grant;
  logic       acc;
  wb_req_t    sel;

  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [XLEN-1:0]       write_data_q, write_data_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({b_valid, a_valid}),
    .accept (acc),
    .grant  (grant)
  );

  assign a_ready = grant[0];
  assign b_ready = grant[1];
  assign acc     = |grant;

  always_comb begin
    sel = '{rd: a_rd, data: a_data};
    if (grant[1]) sel = '{rd: b_rd, data: b_data};
  end

  always_comb begin
    reg_write_d  = acc && (sel.rd != '0);
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (acc) begin
      write_reg_d  = sel.rd;
      write_data_d = sel.data;
    end
  end

  // Clear before set so a same-cycle issue wins.
  always_comb begin
    busy_d = flush ? '0 : busy_q;
    if (acc) busy_d[sel.rd] = 1'b0;
    if (issue_valid) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign busy_vec   = busy_q;
  assign rs1_busy   = busy_q[chk_rs1];
  assign rs2_busy   = busy_q[chk_rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a
// per-cycle reference model and literal spot checks.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 0, b_valid = 0;
  logic [4:0]  a_rd = 0, b_rd = 0;
  logic [31:0] a_data = 0, b_data = 0;
  logic        a_ready, b_ready;
  logic        issue_valid = 0;
  logic [4:0]  issue_rd = 0;
  logic        flush = 0;
  logic [4:0]  chk_rs1 = 0, chk_rs2 = 0;
  logic        rs1_busy, rs2_busy;
  logic [31:0] busy_vec;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  int checks = 0;
  int failures = 0;
  bit mon_en = 0;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_rd       (a_rd),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_rd       (b_rd),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .flush      (flush),
    .chk_rs1    (chk_rs1),
    .chk_rs2    (chk_rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .busy_vec   (busy_vec),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h",
               nm, act, exp);
    end
  endtask

  // Reference model state (value seen after the last edge)
  bit        m_last_b = 1;
  bit [31:0] m_busy = 0;
  bit        m_rw = 0;
  bit [4:0]  m_wr = 0;
  bit [31:0] m_wd = 0;

  always @(negedge clk) begin
    bit ga, gb, st, cl;
    bit [4:0]  rd;
    bit [31:0] nb;
    if (mon_en) begin
      ga = a_valid && (!b_valid || m_last_b);
      gb = b_valid && !ga;
      chk("mon_a_ready", a_ready, ga);
      chk("mon_b_ready", b_ready, gb);
      chk("mon_busy_vec", busy_vec, m_busy);
      chk("mon_rs1_busy", rs1_busy, m_busy[chk_rs1]);
      chk("mon_rs2_busy", rs2_busy, m_busy[chk_rs2]);
      chk("mon_reg_write", reg_write, m_rw);
      if (m_rw) begin
        chk("mon_write_reg", write_reg, m_wr);
        chk("mon_write_data", write_data, m_wd);
      end
      if (rst) begin
        m_busy = 0; m_last_b = 1;
        m_rw = 0; m_wr = 0; m_wd = 0;
      end else begin
        rd = gb ? b_rd : a_rd;
        for (int i = 0; i < 32; i++) begin
          st = issue_valid && issue_rd == i && i != 0;
          cl = flush || ((ga || gb) && rd == i);
          nb[i] = st ? 1'b1 : (cl ? 1'b0 : m_busy[i]);
        end
        m_busy = nb;
        if (ga || gb) begin
          m_last_b = gb;
          m_rw = (rd != 0);
          m_wr = rd;
          m_wd = gb ? b_data : a_data;
        end else begin
          m_rw = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg_write", reg_write, 0);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_busy_vec", busy_vec, 0);
    rst = 0;
    mon_en = 1;

    // Single A write
    a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
    #1 chk("a_only_ready", a_ready, 1);
    chk("a_only_b_ready", b_ready, 0);
    cyc();
    a_valid = 0;
    chk("a_only_rw", reg_write, 1);
    chk("a_only_wr", write_reg, 5);
    chk("a_only_wd", write_data, 32'hDEADBEEF);

    // B alone, so B becomes last_grant
    b_valid = 1; b_rd = 10; b_data = 32'h1234;
    #1 chk("b_only_ready", b_ready, 1);
    cyc();
    b_valid = 0;
    chk("b_only_wr", write_reg, 10);

    // Tie for 4 cycles: A, B, A, B
    a_valid = 1; a_rd = 3; a_data = 32'hA3;
    b_valid = 1; b_rd = 4; b_data = 32'hB4;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_a_ready", a_ready, (i % 2) == 0);
      chk("rr_b_ready", b_ready, (i % 2) == 1);
      cyc();
      chk("rr_wr", write_reg, (i % 2) == 0 ? 3 : 4);
      chk("rr_wd", write_data,
          (i % 2) == 0 ? 32'hA3 : 32'hB4);
    end
    a_valid = 0; b_valid = 0;
    cyc();

    // Issue rd 7, B writes it two cycles later
    issue_valid = 1; issue_rd = 7; chk_rs1 = 7;
    cyc();
    issue_valid = 0;
    chk("iss7_bit", busy_vec[7], 1);
    chk("iss7_rs1", rs1_busy, 1);
    cyc();
    b_valid = 1; b_rd = 7; b_data = 32'h77;
    #1 chk("wb7_ready", b_ready, 1);
    chk("wb7_nobypass", rs1_busy, 1);
    cyc();
    b_valid = 0;
    chk("wb7_rs1", rs1_busy, 0);
    chk("wb7_bit", busy_vec[7], 0);

    // Issue and write to same rd: set wins
    issue_valid = 1; issue_rd = 9;
    a_valid = 1; a_rd = 9; a_data = 32'h99;
    cyc();
    issue_valid = 0; a_valid = 0;
    chk("same9_bit", busy_vec[9], 1);
    chk("same9_wr", write_reg, 9);

    // Write and issue to x0
    a_valid = 1; a_rd = 0; a_data = 32'h55AA;
    #1 chk("x0_ready", a_ready, 1);
    cyc();
    a_valid = 0;
    chk("x0_rw", reg_write, 0);
    issue_valid = 1; issue_rd = 0;
    cyc();
    issue_valid = 0;
    chk("x0_busy", busy_vec, 32'h200);

    // Flush with issue and write in the same cycle
    for (int r = 1; r <= 3; r++) begin
      issue_valid = 1; issue_rd = r[4:0];
      cyc();
    end
    issue_valid = 0;
    chk("pre_flush", busy_vec, 32'h20E);
    chk_rs2 = 2;
    #1 chk("pre_flush_rs2", rs2_busy, 1);
    flush = 1; issue_valid = 1; issue_rd = 6;
    a_valid = 1; a_rd = 12; a_data = 32'hC0FFEE;
    cyc();
    flush = 0; issue_valid = 0; a_valid = 0;
    chk("flush_busy", busy_vec, 32'h40);
    chk("flush_rw", reg_write, 1);
    chk("flush_wr", write_reg, 12);

    // Reset overrides everything in the same cycle
    rst = 1;
    a_valid = 1; a_rd = 13; a_data = 32'h1313;
    b_valid = 1; b_rd = 14; b_data = 32'h1414;
    issue_valid = 1; issue_rd = 8;
    #1 chk("rst_b_ready", b_ready, 1);
    cyc();
    rst = 0; b_valid = 0; issue_valid = 0;
    chk("rst2_rw", reg_write, 0);
    chk("rst2_wr", write_reg, 0);
    chk("rst2_wd", write_data, 0);
    chk("rst2_busy", busy_vec, 0);
    b_valid = 1;
    #1 chk("post_rst_tie_a", a_ready, 1);
    cyc();
    a_valid = 0; b_valid = 0;
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters, one per line: XLEN, 32, data width; NUM_REGS, 32, architectural registers; REG_ADDR_W, 5, register index width.
REQ-002 Ports, one per line:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A (pipeline writeback) has a write.
- a_rd  in  5  destination index for A.
- a_data  in  32  write data for A.
- a_ready  out  1  A's write accepted this cycle.
- b_valid, b_rd, b_data, b_ready  same widths and meaning for requester B (multicycle unit).
- issue_valid  in  1  instruction issued with a destination.
- issue_rd  in  5  destination being issued.
- flush  in  1  discard all pending-destination state.
- chk_rs1, chk_rs2  in  5  source indices to look up.
- rs1_busy, rs2_busy  out  1  source has an outstanding write.
- busy_vec  out  32  pending-destination scoreboard.
- reg_write, write_reg, write_data  out  1/5/32  drive to the register-file write port.

Function
REQ-003 A requester's write SHALL complete when valid and ready are both high; requesters SHALL hold valid, rd and data stable until ready.
REQ-004 Ready SHALL be combinational, at most one ready high per cycle, and never high without its valid.
REQ-005 Only one valid: that requester SHALL be granted the same cycle.
REQ-006 Both valid: the requester not granted most recently SHALL be granted (round-robin); last_grant SHALL update only on an accepted write.
REQ-007 An accepted write SHALL appear on reg_write/write_reg/write_data in the next cycle (1-cycle latency, registered outputs); with no accepted write, reg_write SHALL be 0 next cycle.
REQ-008 An accepted write with rd = 0 SHALL complete normally but drive reg_write = 0 next cycle.
REQ-009 busy_vec[issue_rd] SHALL be set next cycle when issue_valid = 1 and issue_rd != 0.
REQ-010 busy_vec[rd] SHALL be cleared next cycle when a write to rd is accepted.
REQ-011 Issue and accepted write targeting the same rd in the same cycle: the set SHALL win.
REQ-012 flush SHALL clear all of busy_vec next cycle; an issue in the same cycle SHALL still set its bit, and a write accepted in the same cycle SHALL still reach the write port.
REQ-013 busy_vec[0] SHALL always read 0.
REQ-014 rsN_busy SHALL be the combinational value busy_vec[chk_rsN] from registered state, with no same-cycle bypass.
REQ-015 Neither requester SHALL wait more than one cycle while the other is also continuously valid.

Reset
REQ-016 While rst is high at a clock edge: reg_write, write_reg, write_data and busy_vec SHALL be 0, and last_grant SHALL be B, so A wins the first tie.
REQ-017 Reset SHALL override issue, flush and any handshake in the same cycle.
REQ-018 Ready outputs SHALL remain combinational during reset; writes accepted during the reset cycle SHALL be dropped.

Structure
REQ-019 XLEN, NUM_REGS, REG_ADDR_W and the grant encoding (GRANT_A, GRANT_B) SHALL live in a shared package used by the datapath.
REQ-020 Two-way round-robin selection SHALL be a sub-module rr_arbiter2 (req[1:0], accept, grant[1:0], internal last_grant).
REQ-021 The scoreboard and the output register stage SHALL be in regfile_wb_arbiter itself.

Verification
REQ-022 Reset, then A valid only (rd = 5, data = 0xDEADBEEF) -> a_ready = 1 same cycle; next cycle reg_write = 1, write_reg = 5, write_data = 0xDEADBEEF.
REQ-023 A and B both continuously valid for 4 cycles (rd 3 and rd 4) -> grants A, B, A, B; reg_write outputs alternate rd 3/4 one cycle later.
REQ-024 issue rd = 7, then B writes rd = 7 two cycles later -> busy_vec[7] = 1 between; chk_rs1 = 7 gives rs1_busy = 1, then 0 after the write.
REQ-025 Same cycle: issue_valid with rd = 9 and accepted A write to rd = 9 -> busy_vec[9] = 1 next cycle.
REQ-026 Write to rd = 0 accepted -> ready high, reg_write = 0 next cycle; issue rd = 0 -> busy_vec stays 0.
REQ-027 busy bits 1, 2, 3 set, then flush with issue rd = 6 -> busy_vec = 0x00000040; rst with valid inputs -> all outputs 0 next cycle.
